gray_counter: RTL

Parametrised, registered Gray-code counter that keeps a binary count and its Gray encoding in lock-step. It supports up/down counting, synchronous clear, Gray-encoded load, and wrap or saturate modes. It is the pointer generator for clock-domain-crossing FIFOs and the position counter for multi-bit status crossings. Only `gray_out` is meant to cross clock domains. It is guaranteed to change by exactly one bit per count step.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray2bin.sv | 14 +
 rtl/gray_counter.sv | 108 ++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: end-behaviour selectors, next-state decode type and the
// binary-to-Gray encoder used by counters and FIFO pointer blocks.
package gray_pkg;

  // Values for the SATURATE parameter of gray_counter.
  localparam int unsigned GRAY_WRAP = 0;
  localparam int unsigned GRAY_SAT  = 1;

  // Widest pointer the shared encoder handles; narrower callers zero-extend and truncate.
  localparam int unsigned GRAY_MAX_DW = 64;

  // Per-edge action after priority resolution.
  typedef enum logic [1:0] {
    OpHold,
    OpClr,
    OpLoad,
    OpStep
  } gray_op_e;

  function automatic logic [GRAY_MAX_DW-1:0] bin2gray(input logic [GRAY_MAX_DW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all Gray bits
// at and above its position.
module gray2bin #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] gray,
  output logic [DW-1:0] bin
);

  for (genvar i = 0; i < DW; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/gray_counter.sv
// Registered Gray-code counter keeping a binary count and its Gray encoding in lock-step,
// with up/down stepping, synchronous clear, Gray-encoded load and wrap or saturate ends.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned   DW       = 32,
  parameter int unsigned   SATURATE = GRAY_WRAP,
  parameter logic [DW-1:0] RSTVAL   = '0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          dir,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_gray,
  output logic [DW-1:0] bin_out,
  output logic [DW-1:0] gray_out,
  output logic          wrap,
  output logic          sat
);

  localparam bit            SatMode = (SATURATE == GRAY_SAT);
  localparam logic [DW-1:0] RstGray = DW'(bin2gray(GRAY_MAX_DW'(RSTVAL)));

  logic [DW-1:0] bin_q, bin_d;
  logic [DW-1:0] gray_q, gray_d;
  logic          wrap_q, wrap_d;
  logic          sat_q, sat_d;

  logic [DW-1:0] load_bin;
  logic [DW-1:0] step_bin;
  logic          at_end;
  gray_op_e      op;

  gray2bin #(
    .DW(DW)
  ) u_gray2bin (
    .gray(load_gray),
    .bin (load_bin)
  );

  assign step_bin = dir ? (bin_q - DW'(1)) : (bin_q + DW'(1));
  // The step in the current direction would cross the 0 / all-ones boundary.
  assign at_end   = dir ? (bin_q == '0) : (bin_q == '1);

  always_comb begin
    if (clr) begin
      op = OpClr;
    end else if (load) begin
      op = OpLoad;
    end else if (en) begin
      op = OpStep;
    end else begin
      op = OpHold;
    end
  end

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    unique case (op)
      OpClr: begin
        bin_d  = '0;
        gray_d = '0;
        sat_d  = 1'b0;
      end
      OpLoad: begin
        bin_d  = load_bin;
        gray_d = load_gray;
        sat_d  = 1'b0;
      end
      OpStep: begin
        if (SatMode && at_end) begin
          sat_d = 1'b1;
        end else begin
          bin_d  = step_bin;
          gray_d = DW'(bin2gray(GRAY_MAX_DW'(step_bin)));
          wrap_d = !SatMode && at_end;
          sat_d  = 1'b0;
        end
      end
      OpHold: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      bin_q  <= RSTVAL;
      gray_q <= RstGray;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule
